update_pac: RTL and testbench



---
 rtl/pac_pkg.sv | 27 ++
 rtl/pac_next_pos.sv | 81 ++++++++
 rtl/update_pac.sv | 143 ++++++++++++++
 tb/tb_update_pac.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pac_pkg.sv
// Shared types and constants for the Pac-Man position engine.
package pac_pkg;

   localparam int GRID_W_DEF = 32;
   localparam int GRID_H_DEF = 32;

   localparam logic [3:0] TILE_EMPTY = 4'd0;
   localparam logic [3:0] TILE_WALL  = 4'd1;
   localparam logic [3:0] TILE_PAC   = 4'd2;

   typedef enum logic [2:0] {
      DIR_NONE,
      DIR_UP,
      DIR_DOWN,
      DIR_LEFT,
      DIR_RIGHT
   } dir_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_RUN,
      ST_ERASE,
      ST_DRAW
   } state_t;

endpackage

// File: rtl/pac_next_pos.sv
// Combinational target-tile calculator: one step from row/col in direction dir.
// Edge behaviour selected by UPDATE_PAC_WRAP_EN: defined = tunnel wrap to the
// opposite edge, undefined = off-grid moves are reported invalid.
module pac_next_pos
   import pac_pkg::*;
#(
   parameter int GRID_W = GRID_W_DEF,
   parameter int GRID_H = GRID_H_DEF
) (
   input  logic [4:0] row,
   input  logic [4:0] col,
   input  dir_t       dir,
   output logic [4:0] next_row,
   output logic [4:0] next_col,
   output logic       valid
);

   localparam logic [4:0] ROW_MAX = 5'(GRID_H - 1);
   localparam logic [4:0] COL_MAX = 5'(GRID_W - 1);

   // Step one tile; at a grid edge either wrap or flag the move invalid.
   always_comb begin
      next_row = row;
      next_col = col;
      valid    = 1'b0;
      case (dir)
         DIR_UP: begin
            if (row != 5'd0) begin
               next_row = row - 5'd1;
               valid    = 1'b1;
            end
`ifdef UPDATE_PAC_WRAP_EN
            else begin
               next_row = ROW_MAX;
               valid    = 1'b1;
            end
`endif
         end
         DIR_DOWN: begin
            if (row != ROW_MAX) begin
               next_row = row + 5'd1;
               valid    = 1'b1;
            end
`ifdef UPDATE_PAC_WRAP_EN
            else begin
               next_row = 5'd0;
               valid    = 1'b1;
            end
`endif
         end
         DIR_LEFT: begin
            if (col != 5'd0) begin
               next_col = col - 5'd1;
               valid    = 1'b1;
            end
`ifdef UPDATE_PAC_WRAP_EN
            else begin
               next_col = COL_MAX;
               valid    = 1'b1;
            end
`endif
         end
         DIR_RIGHT: begin
            if (col != COL_MAX) begin
               next_col = col + 5'd1;
               valid    = 1'b1;
            end
`ifdef UPDATE_PAC_WRAP_EN
            else begin
               next_col = 5'd0;
               valid    = 1'b1;
            end
`endif
         end
         default: begin
            valid = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/update_pac.sv
// Pac-Man position engine: steps the Pac-Man tile at a fixed rate in the held
// joystick direction and emits erase/draw writes to the tile-map RAM.
// Optional tunnel wrap at grid edges: define UPDATE_PAC_WRAP_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start, no writes
// ST_INIT  | drawing Pac-Man at the start tile
// ST_RUN   | counting to the next move attempt
// ST_ERASE | writing TILE_EMPTY at the old position
// ST_DRAW  | writing TILE_PAC at the new position, position updated
module update_pac
   import pac_pkg::*;
#(
   parameter int GRID_W    = GRID_W_DEF,
   parameter int GRID_H    = GRID_H_DEF,
   parameter int START_ROW = 16,
   parameter int START_COL = 16,
   parameter int MOVE_DIV  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       up,
   input  logic       down,
   input  logic       left,
   input  logic       right,
   output logic [9:0] write_addr,
   output logic [3:0] write_data,
   output logic       wren
);

   localparam int              CNT_W      = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MOVE_DIV - 1);
   localparam logic [4:0]      START_R    = 5'(START_ROW);
   localparam logic [4:0]      START_C    = 5'(START_COL);
   localparam logic [9:0]      START_ADDR = 10'(START_ROW * GRID_W + START_COL);

   state_t           state;
   logic [4:0]       row, col;
   logic [4:0]       tgt_row, tgt_col;
   logic [CNT_W-1:0] cnt;
   dir_t             dir;
   logic [4:0]       nxt_row, nxt_col;
   logic             nxt_valid;

   function automatic logic [9:0] tile_addr(input logic [4:0] r, input logic [4:0] c);
      return 10'(r) * 10'(GRID_W) + 10'(c);
   endfunction

   // Joystick priority: up > down > left > right.
   always_comb begin
      dir = DIR_NONE;
      if (up)
         dir = DIR_UP;
      else if (down)
         dir = DIR_DOWN;
      else if (left)
         dir = DIR_LEFT;
      else if (right)
         dir = DIR_RIGHT;
   end

   pac_next_pos #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H)
   ) u_next_pos (
      .row      (row),
      .col      (col),
      .dir      (dir),
      .next_row (nxt_row),
      .next_col (nxt_col),
      .valid    (nxt_valid)
   );

   // Sequencer: move timer, position registers and registered write port.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         row        <= START_R;
         col        <= START_C;
         tgt_row    <= 5'd0;
         tgt_col    <= 5'd0;
         cnt        <= '0;
         wren       <= 1'b0;
         write_addr <= 10'd0;
         write_data <= 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               wren <= 1'b0;
               if (start) begin
                  state      <= ST_INIT;
                  row        <= START_R;
                  col        <= START_C;
                  wren       <= 1'b1;
                  write_addr <= START_ADDR;
                  write_data <= TILE_PAC;
               end
            end
            ST_INIT: begin
               state <= ST_RUN;
               wren  <= 1'b0;
               cnt   <= '0;
            end
            ST_RUN: begin
               wren <= 1'b0;
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (nxt_valid) begin
                     tgt_row    <= nxt_row;
                     tgt_col    <= nxt_col;
                     state      <= ST_ERASE;
                     wren       <= 1'b1;
                     write_addr <= tile_addr(row, col);
                     write_data <= TILE_EMPTY;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_ERASE: begin
               state      <= ST_DRAW;
               wren       <= 1'b1;
               write_addr <= tile_addr(tgt_row, tgt_col);
               write_data <= TILE_PAC;
               row        <= tgt_row;
               col        <= tgt_col;
            end
            ST_DRAW: begin
               state <= ST_RUN;
               wren  <= 1'b0;
               cnt   <= '0;
            end
            default: begin
               state <= ST_IDLE;
               wren  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_update_pac.sv
// Scoreboard bench for update_pac: an event-time game model predicts every
// tile-map write (cycle, address, data); a monitor checks what the DUT emits.
module tb_update_pac;

   localparam int GW = 32;
   localparam int GH = 32;
   localparam int SR = 16;
   localparam int SC = 16;
   localparam int MD = 4;

   logic       clk;
   logic       reset, start, up, down, left, right;
   logic [9:0] write_addr;
   logic [3:0] write_data;
   logic       wren;

   update_pac #(
      .GRID_W    (GW),
      .GRID_H    (GH),
      .START_ROW (SR),
      .START_COL (SC),
      .MOVE_DIV  (MD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .up         (up),
      .down       (down),
      .left       (left),
      .right      (right),
      .write_addr (write_addr),
      .write_data (write_data),
      .wren       (wren)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int addr;
      int data;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  edge_cnt = 0;
   bit  rst_q = 1'b0;

   // model state
   bit  active = 1'b0;
   int  mrow = SR;
   int  mcol = SC;
   int  next_sample = 0;
   bit  moved = 1'b0;

   // Game rules evaluated for the clock edge with index e.
   function automatic void model(input bit r, input bit s, input bit u, input bit d,
                                 input bit l, input bit rt, input int e);
      int  dr, dc, tr, tc;
      bit  ok;
      moved = 1'b0;
      if (r) begin
         active = 1'b0;
         exp_q.delete();
         return;
      end
      if (!active) begin
         if (s) begin
            active = 1'b1;
            mrow = SR;
            mcol = SC;
            exp_q.push_back('{e, SR * GW + SC, 2});
            next_sample = e + MD + 1;
         end
         return;
      end
      if (e != next_sample) return;
      dr = 0;
      dc = 0;
      if (u) dr = -1;
      else if (d) dr = 1;
      else if (l) dc = -1;
      else if (rt) dc = 1;
      if (dr == 0 && dc == 0) begin
         next_sample = e + MD;
         return;
      end
      tr = mrow + dr;
      tc = mcol + dc;
      ok = (tr >= 0 && tr < GH && tc >= 0 && tc < GW);
`ifdef UPDATE_PAC_WRAP_EN
      tr = (tr + GH) % GH;
      tc = (tc + GW) % GW;
      ok = 1'b1;
`endif
      if (ok) begin
         exp_q.push_back('{e, mrow * GW + mcol, 0});
         exp_q.push_back('{e + 1, tr * GW + tc, 2});
         mrow = tr;
         mcol = tc;
         next_sample = e + 2 + MD;
         moved = 1'b1;
      end else begin
         next_sample = e + MD;
      end
   endfunction

   task automatic drive(input bit r, input bit s, input bit u, input bit d,
                        input bit l, input bit rt);
      @(negedge clk);
      #1;
      reset = r;
      start = s;
      up    = u;
      down  = d;
      left  = l;
      right = rt;
      model(r, s, u, d, l, rt, edge_cnt + 1);
   endtask

   always @(posedge clk) begin
      edge_cnt = edge_cnt + 1;
      rst_q    = reset;
   end

   // Monitor: compare every DUT write against the scoreboard head.
   always @(negedge clk) begin
      wr_t w;
      if (rst_q) begin
         checks++;
         if (wren !== 1'b0 || write_addr !== 10'd0 || write_data !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d: got wren=%b addr=%0d data=%0d, want 0/0/0",
                     edge_cnt, wren, write_addr, write_data);
         end
      end
      if (wren === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write cycle %0d: got addr=%0d data=%0d, want no write",
                     edge_cnt, write_addr, write_data);
         end else begin
            w = exp_q.pop_front();
            if (w.cyc != edge_cnt || int'(write_addr) != w.addr || int'(write_data) != w.data) begin
               errors++;
               $display("FAIL write: got cycle %0d addr=%0d data=%0d, want cycle %0d addr=%0d data=%0d",
                        edge_cnt, write_addr, write_data, w.cyc, w.addr, w.data);
            end
         end
      end else if (wren !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL wren_unknown cycle %0d: got %b, want 0 or 1", edge_cnt, wren);
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
         checks++;
         errors++;
         w = exp_q.pop_front();
         $display("FAIL missing_write cycle %0d: got wren=0, want addr=%0d data=%0d",
                  edge_cnt, w.addr, w.data);
      end
   end

   initial begin
      bit ru, rd, rl, rr;
      reset = 1'b1;
      start = 1'b0;
      up    = 1'b0;
      down  = 1'b0;
      left  = 1'b0;
      right = 1'b0;

      repeat (3) drive(1, 0, 0, 0, 0, 0);
      repeat (5) drive(0, 0, 0, 0, 0, 0);

      // start, then climb to the top edge
      drive(0, 1, 0, 0, 0, 0);
      repeat (110) drive(0, 0, 1, 0, 0, 0);
      // run right to the right edge
      repeat (110) drive(0, 0, 0, 0, 0, 1);
      // up wins over right even when up is blocked
      repeat (30) drive(0, 0, 1, 0, 0, 1);
      repeat (30) drive(0, 0, 0, 1, 0, 0);
      repeat (30) drive(0, 0, 1, 0, 0, 1);
      // idle joystick, with a start pulse that must be ignored
      repeat (20) drive(0, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0);
      repeat (20) drive(0, 0, 0, 0, 0, 0);

      // reset while the erase write is on the bus
      moved = 1'b0;
      for (int i = 0; i < 60 && !moved; i++) drive(0, 0, 0, 0, 1, 0);
      checks++;
      if (!moved) begin
         errors++;
         $display("FAIL erase_reached: got no move in 60 cycles, want a move");
      end
      drive(1, 0, 0, 0, 0, 0);
      repeat (10) drive(0, 0, 0, 0, 1, 0);
      drive(0, 1, 0, 0, 0, 0);
      repeat (15) drive(0, 0, 0, 1, 0, 0);

      // randomized play
      ru = 0; rd = 0; rl = 0; rr = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(3) == 0) begin
            ru = ($urandom_range(2) == 0);
            rd = ($urandom_range(2) == 0);
            rl = ($urandom_range(2) == 0);
            rr = ($urandom_range(2) == 0);
         end
         drive(($urandom_range(199) == 0), ($urandom_range(29) == 0), ru, rd, rl, rr);
      end

      repeat (20) drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_writes: got %0d outstanding, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
